fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_watchdog.sv | 40 ++++
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding, halt-instruction constants and helpers for the fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned COUNT_W         = 32;
  localparam int unsigned STATE_W         = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  localparam logic [INSTR_W-1:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [INSTR_W-1:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [INSTR_W-1:0] INSTR_ZERO   = 32'h0000_0000;

  // Fetch FSM state encoding; IDLE is the reset state.
  typedef logic [STATE_W-1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 3'd0;
  localparam fetch_state_t ST_REQ   = 3'd1;
  localparam fetch_state_t ST_HOLD  = 3'd2;
  localparam fetch_state_t ST_DRAIN = 3'd3;
  localparam fetch_state_t ST_HALT  = 3'd4;

  // Words that stop fetching once decode has consumed them.
  function automatic logic is_halt_instr(input logic [INSTR_W-1:0] word);
    return (word == INSTR_ECALL) || (word == INSTR_EBREAK) || (word == INSTR_ZERO);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) ();

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_watchdog.sv
// Counts cycles spent waiting on imem; expired is registered and rises in the
// TIMEOUT-th enabled cycle after clear, so the FSM can give up on that cycle.
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturating count; clear has priority over enable.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_W'(TIMEOUT))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      expired <= 1'b0;
    end else begin
      count_q <= count_d;
      expired <= (count_d >= CNT_W'(TIMEOUT - 1));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: requests pc_in from imem, holds the word
// for decode, and handles redirects, halts and memory timeouts.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               branch,
  fetch_if.master            mem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               decode_ready,
  output logic               pc_advance,
  output logic               finish_flag,
  output logic               fetch_err,
  output logic [COUNT_W-1:0] retired_count
);

  fetch_state_t       state_q;
  fetch_state_t       state_d;
  logic               imem_req_q;
  logic               imem_req_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_d;
  logic [INSTR_W-1:0] instr_d;
  logic [ADDR_W-1:0]  instr_pc_d;
  logic               instr_valid_d;
  logic               pc_advance_d;
  logic               finish_d;
  logic               err_d;
  logic [COUNT_W-1:0] retired_d;
  logic               wd_clear;
  logic               wd_enable;
  logic               wd_expired;
  logic               consume;

  assign mem.imem_req  = imem_req_q;
  assign mem.imem_addr = addr_q;

  assign consume   = (state_q == ST_HOLD) && decode_ready;
  assign wd_enable = (state_q == ST_REQ) || (state_q == ST_DRAIN);

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    state_d       = state_q;
    imem_req_d    = 1'b0;
    addr_d        = addr_q;
    instr_d       = instr;
    instr_pc_d    = instr_pc;
    instr_valid_d = 1'b0;
    pc_advance_d  = 1'b0;
    finish_d      = finish_flag;
    err_d         = fetch_err;
    retired_d     = retired_count;
    wd_clear      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pc_in[1:0] != 2'b00) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          addr_d     = pc_in;
          imem_req_d = 1'b1;
          wd_clear   = 1'b1;
          state_d    = ST_REQ;
        end
      end

      ST_REQ: begin
        if (mem.imem_ack) begin
          if (branch) begin
            state_d = ST_IDLE;
          end else begin
            instr_d       = mem.imem_rdata;
            instr_pc_d    = addr_q;
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          imem_req_d = 1'b1;
          if (branch) begin
            state_d = ST_DRAIN;
          end
        end
      end

      // The outstanding request stays up until acked; its data is thrown away.
      ST_DRAIN: begin
        if (mem.imem_ack) begin
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          imem_req_d = 1'b1;
        end
      end

      // A consume wins over a simultaneous branch.
      ST_HOLD: begin
        if (consume) begin
          pc_advance_d = 1'b1;
          retired_d    = retired_count + COUNT_W'(1);
          if (is_halt_instr(instr)) begin
            finish_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (branch) begin
          state_d = ST_IDLE;
        end else begin
          instr_valid_d = 1'b1;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      imem_req_q    <= 1'b0;
      addr_q        <= '0;
      instr         <= '0;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
      pc_advance    <= 1'b0;
      finish_flag   <= 1'b0;
      fetch_err     <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      addr_q        <= addr_d;
      instr         <= instr_d;
      instr_pc      <= instr_pc_d;
      instr_valid   <= instr_valid_d;
      pc_advance    <= pc_advance_d;
      finish_flag   <= finish_d;
      fetch_err     <= err_d;
      retired_count <= retired_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected decode handoffs are queued by the
// stimulus and checked by an independent consume monitor.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned ADDR_W = 32;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        branch;
  logic        decode_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        pc_advance;
  logic        finish_flag;
  logic        fetch_err;
  logic [31:0] retired_count;

  fetch_if #(.ADDR_W(ADDR_W)) mem_bus ();

  fetch_unit #(
    .TIMEOUT (16),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .branch        (branch),
    .mem           (mem_bus),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .decode_ready  (decode_ready),
    .pc_advance    (pc_advance),
    .finish_flag   (finish_flag),
    .fetch_err     (fetch_err),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  int          cons_q[$];
  exp_t        mon_e;
  logic [31:0] mem_words [logic [31:0]];
  logic [31:0] halt_words [3];
  int          lat = 0;
  bit          no_ack = 1'b0;
  int          ack_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem_words.exists(a) ? mem_words[a] : 32'h0000_0013;
  endfunction

  task automatic push_exp(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e.instr = w;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // One cycle: memory responder with programmable latency, PC stage, branch pulse end.
  task automatic tick();
    @(posedge clk);
    #1;
    branch = 1'b0;
    if (!reset || no_ack) begin
      mem_bus.imem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_bus.imem_ack) begin
      mem_bus.imem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_bus.imem_req) begin
      if (ack_cnt >= lat) begin
        mem_bus.imem_ack   = 1'b1;
        mem_bus.imem_rdata = word_at(mem_bus.imem_addr);
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
    if (pc_advance) pc_in = pc_in + 32'd4;
  endtask

  // Reset is asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input logic [31:0] pc);
    reset        = 1'b0;
    branch       = 1'b0;
    decode_ready = 1'b0;
    no_ack       = 1'b0;
    #1;
    check("rst_flags", 32'({mem_bus.imem_req, instr_valid, pc_advance, finish_flag, fetch_err}), 32'd0);
    check("rst_addr", mem_bus.imem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_retired", retired_count, 32'd0);
    tick();
    tick();
    pc_in = pc;
    reset = 1'b1;
  endtask

  task automatic wait_req(input string name, input int lim);
    for (int k = 0; k < lim && !mem_bus.imem_req; k++) tick();
    check(name, 32'(mem_bus.imem_req), 32'd1);
  endtask

  task automatic wait_valid(input string name, input int lim);
    for (int k = 0; k < lim && !instr_valid; k++) tick();
    check(name, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_retired(input string name, input logic [31:0] n, input int lim);
    for (int k = 0; k < lim && retired_count != n; k++) tick();
    check(name, retired_count, n);
  endtask

  // Consume monitor: every handoff to decode must match the next queued expectation.
  always @(negedge clk) begin
    if (reset && instr_valid && decode_ready) begin
      cons_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_consume: got pc 0x%08h, expected no consume", instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("consume_instr", instr, mon_e.instr);
        check("consume_pc", instr_pc, mon_e.pc);
      end
    end
  end

  initial begin
    bit ok;
    int n;
    reset              = 1'b1;
    pc_in              = '0;
    branch             = 1'b0;
    decode_ready       = 1'b0;
    mem_bus.imem_ack   = 1'b0;
    mem_bus.imem_rdata = '0;
    mem_words[32'h40]  = 32'hDEAD_BEEF;
    mem_words[32'h100] = 32'h00A0_0093;
    mem_words[32'h500] = 32'h0020_8113;
    halt_words[0]      = 32'h0010_0073;
    halt_words[1]      = 32'h0000_0073;
    halt_words[2]      = 32'h0000_0000;
    #2;

    // Zero-wait stream of nops, then a branch while the fourth word is held.
    do_reset(32'h0);
    lat = 0;
    decode_ready = 1'b1;
    cons_q.delete();
    push_exp(32'h13, 32'h0);
    push_exp(32'h13, 32'h4);
    push_exp(32'h13, 32'h8);
    wait_retired("stream_retired", 32'd3, 40);
    decode_ready = 1'b0;
    if (cons_q.size() == 3) begin
      check("gap_0_1", 32'(cons_q[1] - cons_q[0]), 32'd3);
      check("gap_1_2", 32'(cons_q[2] - cons_q[1]), 32'd3);
    end else begin
      n_vec++;
      n_fail++;
      $display("FAIL consume_count: got %0d, expected 3", cons_q.size());
    end
    wait_valid("hold4_valid", 10);
    check("hold4_pc", instr_pc, 32'hC);
    branch = 1'b1;
    pc_in  = 32'h100;
    tick();
    check("hold_branch_valid", 32'({instr_valid, pc_advance}), 32'd0);
    check("hold_branch_retired", retired_count, 32'd3);
    tick();
    check("hold_branch_req", 32'(mem_bus.imem_req), 32'd1);
    check("hold_branch_addr", mem_bus.imem_addr, 32'h100);

    // Slow memory, branch in the second REQ cycle: drain then refetch 0x100.
    do_reset(32'h40);
    lat = 5;
    wait_req("drain_req", 10);
    tick();
    branch = 1'b1;
    pc_in  = 32'h100;
    ok = 1'b1;
    for (int k = 0; k < 20 && !mem_bus.imem_ack; k++) begin
      tick();
      if (!(mem_bus.imem_req && mem_bus.imem_addr == 32'h40)) ok = 1'b0;
    end
    check("drain_ack_seen", 32'(mem_bus.imem_ack), 32'd1);
    check("drain_addr_stable", 32'(ok), 32'd1);
    tick();
    check("drain_idle", 32'({mem_bus.imem_req, instr_valid}), 32'd0);
    tick();
    check("drain_new_addr", mem_bus.imem_addr, 32'h100);
    push_exp(32'h00A0_0093, 32'h100);
    decode_ready = 1'b1;
    wait_retired("drain_retired", 32'd1, 20);
    decode_ready = 1'b0;

    // Branch coincident with ack in REQ discards the word.
    do_reset(32'h20);
    lat = 0;
    wait_req("brack_req", 10);
    branch = 1'b1;
    pc_in  = 32'h200;
    tick();
    check("brack_idle", 32'({mem_bus.imem_req, instr_valid}), 32'd0);
    tick();
    check("brack_new_addr", mem_bus.imem_addr, 32'h200);
    check("brack_retired", retired_count, 32'd0);

    // Each halt word stops fetching once consumed.
    foreach (halt_words[i]) begin
      mem_words[32'h300] = halt_words[i];
      do_reset(32'h300);
      lat = 0;
      decode_ready = 1'b1;
      push_exp(halt_words[i], 32'h300);
      for (int k = 0; k < 20 && !finish_flag; k++) tick();
      check("halt_finish", 32'(finish_flag), 32'd1);
      check("halt_advance", 32'(pc_advance), 32'd1);
      check("halt_retired", retired_count, 32'd1);
      ok = 1'b1;
      repeat (20) begin
        tick();
        if (mem_bus.imem_req || instr_valid) ok = 1'b0;
      end
      check("halt_quiet", 32'(ok), 32'd1);
    end

    // Misaligned PC: error, no request, stays halted.
    do_reset(32'h6);
    lat = 0;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 4) pc_in = 32'h8;
      if (mem_bus.imem_req) ok = 1'b0;
    end
    check("misalign_no_req", 32'(ok), 32'd1);
    check("misalign_err", 32'(fetch_err), 32'd1);

    // No ack at all: request held for exactly TIMEOUT cycles.
    do_reset(32'h400);
    no_ack = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mem_bus.imem_req) n++;
      else if (n > 0) break;
    end
    check("timeout_req_cycles", 32'(n), 32'd16);
    check("timeout_err", 32'(fetch_err), 32'd1);
    check("timeout_req_low", 32'(mem_bus.imem_req), 32'd0);

    // Reset while holding a word, then restart from the redirected PC.
    do_reset(32'h500);
    lat = 0;
    wait_valid("rsthold_valid", 10);
    check("rsthold_instr", instr, 32'h0020_8113);
    do_reset(32'h600);
    wait_req("rsthold_req", 10);
    check("rsthold_addr", mem_bus.imem_addr, 32'h600);

    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
